// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath among NREQ requesters.
// Optional MUL-cycle watchdog enabled by defining MULT_WDOG_EN.
module mult_sched #(
    parameter int NREQ = 2,
    parameter int PW   = 16,
    parameter int WDOG = 255,
    localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] ack,
    output logic [SW-1:0]   sel,
    input  logic            eqz,
    input  logic [PW-1:0]   prod,
    output logic            LdA,
    output logic            LdB,
    output logic            LdP,
    output logic            clrP,
    output logic            decB,
    output logic [PW-1:0]   result,
    output logic            busy,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, LOADA, LOADB, MUL, DONE} state_t;

    state_t        state;
    logic [SW-1:0] rr;
    logic [SW-1:0] pick;
    logic          any;
    logic          wdog_hit;

    // Lowest set bit above rr wins; if none above, the lowest overall (wrap).
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int j = NREQ-1; j >= 0; j--) begin
            if (req[j]) begin
                pick = SW'(j);
                any  = 1'b1;
            end
        end
        for (int j = NREQ-1; j >= 0; j--) begin
            if (req[j] && (j > int'(rr)))
                pick = SW'(j);
        end
    end

`ifdef MULT_WDOG_EN
    localparam int WCW = (WDOG > 0) ? $clog2(WDOG+1) : 1;
    logic [WCW-1:0] wcnt;
    assign wdog_hit = (state == MUL) && !eqz && (wcnt == WCW'(WDOG));
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG != 0);
    assign wdog_hit    = 1'b0;
    assign err         = 1'b0;
`endif

    assign LdA  = (state == LOADA);
    assign LdB  = (state == LOADB);
    assign clrP = (state == LOADB);
    assign LdP  = (state == MUL) && !eqz && !wdog_hit;
    assign decB = LdP;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            ack    <= '0;
            sel    <= '0;
            result <= '0;
            rr     <= SW'(NREQ-1);
`ifdef MULT_WDOG_EN
            err    <= 1'b0;
            wcnt   <= '0;
`endif
        end else begin
            ack <= '0;
`ifdef MULT_WDOG_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: if (any) begin
                    gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    sel   <= pick;
                    rr    <= pick;
                    state <= LOADA;
                end
                LOADA: state <= LOADB;
                LOADB: begin
`ifdef MULT_WDOG_EN
                    wcnt  <= '0;
`endif
                    state <= MUL;
                end
                MUL: begin
                    if (eqz || wdog_hit) begin
                        result <= prod;
                        ack    <= gnt;
                        state  <= DONE;
                    end
`ifdef MULT_WDOG_EN
                    if (wdog_hit) err  <= 1'b1;
                    else          wcnt <= wcnt + 1'b1;
`endif
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
